reorder_buffer: RTL and testbench

- Circular in-order reorder buffer between dispatch and the architectural register file.
- Allocates one tag per dispatched instruction and returns it on rob_free_entry, which dispatch writes into the register-file tag table.
- Captures results from the completion bus and supplies not-yet-committed operand values to dispatch by tag.
- Retires the oldest completed entry each cycle by driving the register-file write port (we, write_reg, write_tag, write_data).

---
 rtl/reorder_buffer.sv | 120 ++++++++++++
 tb/tb_reorder_buffer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at dispatch, captures CDB
// results, forwards operands by tag and retires the oldest done entry.
module reorder_buffer #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mispred,
  input  logic        dc_valid,
  input  logic [5:0]  dc_rd,
  output logic [5:0]  rob_free_entry,
  output logic        rob_full,
  output logic [6:0]  rob_count,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  input  logic [5:0]  read_tag1,
  input  logic [5:0]  read_tag2,
  output logic [32:0] rob_data1,
  output logic [32:0] rob_data2,
  output logic        we,
  output logic [5:0]  write_reg,
  output logic [5:0]  write_tag,
  output logic [31:0] write_data
);

  localparam logic [5:0] MASK = 6'(DEPTH - 1);
  localparam logic [6:0] FULL = 7'(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] done;
  logic [5:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic [5:0] head;
  logic [5:0] tail;
  logic [6:0] count;

  logic       alloc;
  logic       commit;
  logic       complete;
  logic [5:0] cdb_idx;
  logic [5:0] rd1_idx;
  logic [5:0] rd2_idx;

  function automatic logic [5:0] wrap_inc(input logic [5:0] p);
    return (p == MASK) ? 6'd0 : p + 6'd1;
  endfunction

  assign cdb_idx = cdb_tag & MASK;
  assign rd1_idx = read_tag1 & MASK;
  assign rd2_idx = read_tag2 & MASK;

  assign rob_free_entry = tail;
  assign rob_full       = (count == FULL);
  assign rob_count      = count;

  assign alloc    = dc_valid && !rob_full;
  assign commit   = valid[head] && done[head];
  assign complete = cdb_valid && valid[cdb_idx];

  assign we         = commit;
  assign write_reg  = rd_q[head];
  assign write_tag  = head;
  assign write_data = data_q[head];

  // Control state; commit clear is ordered after completion so it wins.
  always_ff @(posedge clk) begin
    if (reset || mispred) begin
      valid <= '0;
      done  <= '0;
      head  <= 6'd0;
      tail  <= 6'd0;
      count <= 7'd0;
    end else begin
      if (complete) begin
        done[cdb_idx] <= 1'b1;
      end
      if (commit) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
        head        <= wrap_inc(head);
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= wrap_inc(tail);
      end
      unique case ({alloc, commit})
        2'b10:   count <= count + 7'd1;
        2'b01:   count <= count - 7'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; valid/done qualify it.
  always_ff @(posedge clk) begin
    if (!reset && !mispred) begin
      if (complete) begin
        data_q[cdb_idx] <= cdb_data;
      end
      if (alloc) begin
        rd_q[tail] <= dc_rd;
      end
    end
  end

  always_comb begin
    rob_data1 = {done[rd1_idx], data_q[rd1_idx]};
    rob_data2 = {done[rd2_idx], data_q[rd2_idx]};
    if (cdb_valid && cdb_tag == read_tag1) begin
      rob_data1 = {1'b1, cdb_data};
    end
    if (cdb_valid && cdb_tag == read_tag2) begin
      rob_data2 = {1'b1, cdb_data};
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus a randomized run
// against a queue-based in-order model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mispred;
  logic        dc_valid;
  logic [5:0]  dc_rd;
  logic [5:0]  rob_free_entry;
  logic        rob_full;
  logic [6:0]  rob_count;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [5:0]  read_tag1;
  logic [5:0]  read_tag2;
  logic [32:0] rob_data1;
  logic [32:0] rob_data2;
  logic        we;
  logic [5:0]  write_reg;
  logic [5:0]  write_tag;
  logic [31:0] write_data;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset), .mispred(mispred),
    .dc_valid(dc_valid), .dc_rd(dc_rd),
    .rob_free_entry(rob_free_entry), .rob_full(rob_full),
    .rob_count(rob_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .read_tag1(read_tag1), .read_tag2(read_tag2),
    .rob_data1(rob_data1), .rob_data2(rob_data2),
    .we(we), .write_reg(write_reg), .write_tag(write_tag),
    .write_data(write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [5:0]  rd;
    bit          done;
    logic [31:0] data;
  } ent_t;

  task automatic idle();
    mispred   = 1'b0;
    dc_valid  = 1'b0;
    dc_rd     = 6'd0;
    cdb_valid = 1'b0;
    cdb_tag   = 6'd0;
    cdb_data  = 32'd0;
    read_tag1 = 6'd0;
    read_tag2 = 6'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (rob_free_entry !== 6'd0) begin
      errors++;
      $display("FAIL reset_free: got %0d expected 0", rob_free_entry);
    end
    checks++;
    if (rob_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_full: got %0b expected 0", rob_full);
    end
    checks++;
    if (rob_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", rob_count);
    end
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL reset_we: got %0b expected 0", we);
    end
  endtask

  task automatic test_alloc();
    dc_valid = 1'b1;
    dc_rd    = 6'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rob_free_entry !== 6'(i) || we !== 1'b0) begin
        errors++;
        $display("FAIL alloc_tag%0d: got tag %0d we %0b expected tag %0d we 0",
                 i, rob_free_entry, we, i);
      end
      tick();
    end
    dc_valid = 1'b0;
    #1;
    checks++;
    if (rob_count !== 7'd3 || we !== 1'b0) begin
      errors++;
      $display("FAIL alloc_count: got %0d we %0b expected 3 we 0",
               rob_count, we);
    end
  endtask

  task automatic test_commit_order();
    cdb_valid = 1'b1;
    cdb_tag   = 6'd1;
    cdb_data  = 32'hAA;
    tick();
    cdb_tag  = 6'd0;
    cdb_data = 32'h55;
    #1;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass_commit: got we %0b expected 0", we);
    end
    tick();
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (we !== 1'b1 || write_reg !== 6'd5 || write_tag !== 6'd0 ||
        write_data !== 32'h55) begin
      errors++;
      $display("FAIL commit0: got we %0b reg %0d tag %0d data %0h expected 1 5 0 55",
               we, write_reg, write_tag, write_data);
    end
    tick();
    #1;
    checks++;
    if (we !== 1'b1 || write_tag !== 6'd1 || write_data !== 32'hAA) begin
      errors++;
      $display("FAIL commit1: got we %0b tag %0d data %0h expected 1 1 aa",
               we, write_tag, write_data);
    end
    tick();
    #1;
    checks++;
    if (we !== 1'b0 || rob_count !== 7'd1) begin
      errors++;
      $display("FAIL commit_end: got we %0b count %0d expected 0 1",
               we, rob_count);
    end
  endtask

  task automatic test_full();
    do_reset();
    dc_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      dc_rd = 6'(i) ^ 6'h2A;
      tick();
    end
    cdb_valid = 1'b1;
    cdb_tag   = 6'd0;
    cdb_data  = 32'hC0DE;
    #1;
    checks++;
    if (rob_full !== 1'b1 || rob_free_entry !== 6'd0 ||
        rob_count !== 7'd64 || we !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got full %0b free %0d count %0d we %0b expected 1 0 64 0",
               rob_full, rob_free_entry, rob_count, we);
    end
    tick();
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (we !== 1'b1 || rob_full !== 1'b1 || write_reg !== 6'h2A ||
        write_data !== 32'hC0DE || rob_count !== 7'd64) begin
      errors++;
      $display("FAIL full_commit: got we %0b full %0b reg %0h data %0h count %0d",
               we, rob_full, write_reg, write_data, rob_count);
    end
    tick();
    #1;
    checks++;
    if (rob_count !== 7'd63 || rob_full !== 1'b0 || rob_free_entry !== 6'd0) begin
      errors++;
      $display("FAIL full_after_commit: got count %0d full %0b free %0d expected 63 0 0",
               rob_count, rob_full, rob_free_entry);
    end
    tick();
    dc_valid = 1'b0;
    #1;
    checks++;
    if (rob_count !== 7'd64 || rob_full !== 1'b1 || rob_free_entry !== 6'd1) begin
      errors++;
      $display("FAIL full_refill: got count %0d full %0b free %0d expected 64 1 1",
               rob_count, rob_full, rob_free_entry);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    dc_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    dc_valid  = 1'b0;
    read_tag1 = 6'd3;
    read_tag2 = 6'd4;
    cdb_valid = 1'b1;
    cdb_tag   = 6'd3;
    cdb_data  = 32'h1234;
    #1;
    checks++;
    if (rob_data1 !== {1'b1, 32'h1234}) begin
      errors++;
      $display("FAIL bypass_read: got %0h expected 100001234", rob_data1);
    end
    checks++;
    if (rob_data2[32] !== 1'b0) begin
      errors++;
      $display("FAIL unfinished_ready: got %0b expected 0", rob_data2[32]);
    end
    tick();
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (rob_data1 !== {1'b1, 32'h1234}) begin
      errors++;
      $display("FAIL stored_read: got %0h expected 100001234", rob_data1);
    end
  endtask

  task automatic test_mispred();
    do_reset();
    dc_valid = 1'b1;
    dc_rd    = 6'd9;
    for (int i = 0; i < 10; i++) tick();
    dc_valid  = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag   = 6'd0;
    cdb_data  = 32'h77;
    tick();
    cdb_valid = 1'b0;
    mispred   = 1'b1;
    #1;
    checks++;
    if (we !== 1'b1 || write_tag !== 6'd0 || write_data !== 32'h77) begin
      errors++;
      $display("FAIL mispred_commit: got we %0b tag %0d data %0h expected 1 0 77",
               we, write_tag, write_data);
    end
    tick();
    mispred = 1'b0;
    #1;
    checks++;
    if (rob_count !== 7'd0 || rob_free_entry !== 6'd0 || we !== 1'b0) begin
      errors++;
      $display("FAIL mispred_clear: got count %0d free %0d we %0b expected 0 0 0",
               rob_count, rob_free_entry, we);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 6'd4;
    cdb_data  = 32'hDEAD;
    tick();
    cdb_valid = 1'b0;
    read_tag1 = 6'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (we !== 1'b0 || rob_data1[32] !== 1'b0) begin
        errors++;
        $display("FAIL late_cdb_ignored: got we %0b ready %0b expected 0 0",
                 we, rob_data1[32]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dc_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    dc_valid  = 1'b1;
    reset     = 1'b1;
    cdb_valid = 1'b1;
    cdb_tag   = 6'd0;
    cdb_data  = 32'hBEEF;
    #1;
    checks++;
    if (rob_count !== 7'd7) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d expected 7", rob_count);
    end
    tick();
    idle();
    reset     = 1'b0;
    read_tag1 = 6'd0;
    #1;
    checks++;
    if (rob_count !== 7'd0 || rob_full !== 1'b0 || rob_free_entry !== 6'd0 ||
        we !== 1'b0 || rob_data1[32] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got count %0d full %0b free %0d we %0b ready %0b",
               rob_count, rob_full, rob_free_entry, we, rob_data1[32]);
    end
  endtask

  task automatic test_random();
    ent_t        q[$];
    int          next_tag;
    bit          exp_we;
    logic [32:0] exp_rd;
    bit          care;
    logic [5:0]  rt;
    logic [32:0] got;
    ent_t        e;
    do_reset();
    next_tag = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int pct;
      pct       = ((cyc / 250) % 2 == 0) ? 85 : 35;
      dc_valid  = ($urandom_range(99) < pct);
      dc_rd     = 6'($urandom);
      mispred   = ($urandom_range(399) == 0);
      cdb_valid = ($urandom_range(99) < 55);
      if (q.size() > 0 && $urandom_range(9) < 8)
        cdb_tag = 6'(q[$urandom_range(q.size() - 1)].tag);
      else
        cdb_tag = 6'($urandom);
      cdb_data  = $urandom;
      read_tag1 = ($urandom_range(1) == 0) ? cdb_tag : 6'($urandom);
      read_tag2 = 6'($urandom);
      #1;
      exp_we = (q.size() > 0) && q[0].done;
      checks++;
      if (rob_count !== 7'(q.size()) || rob_full !== (q.size() == 64) ||
          rob_free_entry !== 6'(next_tag) || we !== exp_we) begin
        errors++;
        $display("FAIL rnd_status c%0d: got cnt %0d full %0b free %0d we %0b expected %0d %0b %0d %0b",
                 cyc, rob_count, rob_full, rob_free_entry, we,
                 q.size(), q.size() == 64, next_tag, exp_we);
      end
      if (exp_we) begin
        checks++;
        if (write_reg !== q[0].rd || write_tag !== 6'(q[0].tag) ||
            write_data !== q[0].data) begin
          errors++;
          $display("FAIL rnd_commit c%0d: got %0h/%0d/%0h expected %0h/%0d/%0h",
                   cyc, write_reg, write_tag, write_data,
                   q[0].rd, q[0].tag, q[0].data);
        end
      end
      for (int p = 0; p < 2; p++) begin
        rt     = (p == 0) ? read_tag1 : read_tag2;
        got    = (p == 0) ? rob_data1 : rob_data2;
        exp_rd = 33'd0;
        care   = 1'b0;
        if (cdb_valid && cdb_tag == rt) begin
          exp_rd = {1'b1, cdb_data};
          care   = 1'b1;
        end else begin
          foreach (q[k]) begin
            if (q[k].tag == int'(rt) && q[k].done) begin
              exp_rd = {1'b1, q[k].data};
              care   = 1'b1;
            end
          end
        end
        checks++;
        if ((care && got !== exp_rd) || (!care && got[32] !== 1'b0)) begin
          errors++;
          $display("FAIL rnd_read%0d c%0d tag %0d: got %0h expected %0h (data checked %0b)",
                   p + 1, cyc, rt, got, exp_rd, care);
        end
      end
      if (mispred) begin
        q.delete();
        next_tag = 0;
      end else begin
        if (cdb_valid) begin
          foreach (q[k]) begin
            if (q[k].tag == int'(cdb_tag)) begin
              q[k].done = 1'b1;
              q[k].data = cdb_data;
            end
          end
        end
        if (exp_we) void'(q.pop_front());
        if (dc_valid && (q.size() + (exp_we ? 1 : 0)) < 64) begin
          e.tag  = next_tag;
          e.rd   = dc_rd;
          e.done = 1'b0;
          e.data = 32'd0;
          q.push_back(e);
          next_tag = (next_tag + 1) % 64;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_alloc();
    test_commit_order();
    test_full();
    test_bypass();
    test_mispred();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
